// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: latency codes and parameter defaults.
package issue_scoreboard_pkg;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;

  localparam int unsigned NREG_DEF    = 32;
  localparam int unsigned WB_LAT_DEF  = 3;
  localparam int unsigned MAX_LAT_DEF = 3;

  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// ID-stage to scoreboard handshake: source/dest description in, hazard status out.
interface issue_scoreboard_if #(
  parameter int unsigned NRP   = 3,
  parameter int unsigned CNT_W = 2
);
  logic             ds_valid;
  logic             ds_cancel;
  logic             es_allowin;
  logic [NRP-1:0]   src_valid;
  logic [NRP*5-1:0] src_addr;
  logic             gr_we;
  logic [4:0]       dest;
  logic [CNT_W-1:0] lat;
  logic             is_long;
  logic             long_done;
  logic [4:0]       long_waddr;
  logic             ds_ready_go;
  logic             issue;
  logic [NRP-1:0]   src_busy;
  logic [31:0]      stall_cnt;

  modport master (
    output ds_valid, ds_cancel, es_allowin, src_valid, src_addr, gr_we, dest, lat, is_long,
           long_done, long_waddr,
    input  ds_ready_go, issue, src_busy, stall_cnt
  );

  modport slave (
    input  ds_valid, ds_cancel, es_allowin, src_valid, src_addr, gr_we, dest, lat, is_long,
           long_done, long_waddr,
    output ds_ready_go, issue, src_busy, stall_cnt
  );
endinterface

// File: rtl/sb_entry.sv
// One scoreboard entry: short-op countdown plus long-op busy flag for a single register.
module sb_entry #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_cnt_i,
  input  logic [CntW-1:0] cnt_val_i,
  input  logic            set_lb_i,
  input  logic            clr_lb_i,
  output logic [CntW-1:0] cnt_o,
  output logic            lb_o
);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            lb_d, lb_q;

  always_comb begin
    cnt_d = cnt_q;
    if (set_cnt_i) begin
      cnt_d = cnt_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    // A same-cycle long issue outranks the completion of the previous long op.
    lb_d = lb_q;
    if (set_lb_i) begin
      lb_d = 1'b1;
    end else if (clr_lb_i) begin
      lb_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lb_q  <= lb_d;
    end
  end

  assign cnt_o = cnt_q;
  assign lb_o  = lb_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard gating ID issue. Define SB_FWD_EN to use the per-op latency
// (forwarding pipeline); otherwise every short op blocks readers until writeback (WB_LAT).
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NRP     = 3,
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF,
  parameter int unsigned WB_LAT  = WB_LAT_DEF
) (
  input logic                clk,
  input logic                reset,
  issue_scoreboard_if.slave  sb
);

  localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            lb;
  logic [NRP-1:0]             src_busy;
  logic                       waw;
  logic                       ready_go;
  logic                       issue;
  logic                       wr_short;
  logic                       wr_long;
  logic [CNT_W-1:0]           lat_eff;
  logic [31:0]                stall_cnt_d, stall_cnt_q;

`ifdef SB_FWD_EN
  always_comb begin
    lat_eff = sb.lat;
    if (int'(sb.lat) > int'(MAX_LAT)) begin
      lat_eff = CNT_W'(MAX_LAT);
    end
  end
`else
  localparam int unsigned WbLatC = clamp_lat(WB_LAT, MAX_LAT);
  logic [CNT_W-1:0] lat_unused;
  assign lat_unused = sb.lat;
  assign lat_eff    = CNT_W'(WbLatC);
`endif

  assign cnt[0] = '0;
  assign lb[0]  = 1'b0;

  // Hazards are masked during reset so ID sees a clean, idle scoreboard.
  always_comb begin
    src_busy = '0;
    for (int i = 0; i < NRP; i++) begin
      src_busy[i] = !reset && sb.src_valid[i] && (sb.src_addr[5*i +: 5] != 5'd0) &&
                    ((cnt[sb.src_addr[5*i +: 5]] != '0) || lb[sb.src_addr[5*i +: 5]]);
    end
  end

  assign waw      = !reset && sb.gr_we && (sb.dest != 5'd0) && lb[sb.dest];
  assign ready_go = !(|src_busy) && !waw;
  assign issue    = !reset && sb.ds_valid && !sb.ds_cancel && ready_go && sb.es_allowin;
  assign wr_short = issue && sb.gr_we && (sb.dest != 5'd0) && !sb.is_long;
  assign wr_long  = issue && sb.gr_we && (sb.dest != 5'd0) && sb.is_long;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(
      .CntW (CNT_W)
    ) u_entry (
      .clk       (clk),
      .reset     (reset),
      .set_cnt_i (wr_short && (sb.dest == 5'(r))),
      .cnt_val_i (lat_eff),
      .set_lb_i  (wr_long && (sb.dest == 5'(r))),
      .clr_lb_i  (sb.long_done && (sb.long_waddr == 5'(r))),
      .cnt_o     (cnt[r]),
      .lb_o      (lb[r])
    );
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (sb.ds_valid && !sb.ds_cancel && !ready_go && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.src_busy    = src_busy;
  assign sb.ds_ready_go = ready_go;
  assign sb.issue       = issue;
  assign sb.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; covers both the SB_FWD_EN and writeback-stall builds.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int unsigned NRP  = 3;
  localparam int unsigned CntW = $clog2(MAX_LAT_DEF + 1);

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;
  int   exp_stall = 0;

  always #5 clk = ~clk;

  issue_scoreboard_if #(.NRP(NRP), .CNT_W(CntW)) sb_if ();

  issue_scoreboard #(.NRP(NRP)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.ds_valid   = 1'b0;
    sb_if.ds_cancel  = 1'b0;
    sb_if.es_allowin = 1'b0;
    sb_if.src_valid  = '0;
    sb_if.src_addr   = '0;
    sb_if.gr_we      = 1'b0;
    sb_if.dest       = '0;
    sb_if.lat        = '0;
    sb_if.is_long    = 1'b0;
    sb_if.long_done  = 1'b0;
    sb_if.long_waddr = '0;
  endtask

  task automatic go();
    idle();
    sb_if.ds_valid   = 1'b1;
    sb_if.es_allowin = 1'b1;
  endtask

  task automatic set_src(input int port, input logic [4:0] r);
    sb_if.src_valid[port]        = 1'b1;
    sb_if.src_addr[5*port +: 5] = r;
  endtask

  task automatic set_wr(input logic [4:0] d, input logic long_op, input int unsigned l);
    sb_if.gr_we   = 1'b1;
    sb_if.dest    = d;
    sb_if.is_long = long_op;
    sb_if.lat     = CntW'(l);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    sb_if.ds_valid = 1'b1;
    set_wr(5'd3, 1'b0, 3);
    step();
    #1;
    check_eq("rst_ready", 32'(sb_if.ds_ready_go), 32'd1);
    check_eq("rst_issue", 32'(sb_if.issue), 32'd0);
    check_eq("rst_busy", 32'(sb_if.src_busy), 32'd0);
    step();
    reset = 1'b0;
    idle();
    #1;
    check_eq("rst_stall", sb_if.stall_cnt, 32'd0);

`ifdef SB_FWD_EN
    go(); set_wr(5'd5, 1'b0, LAT_ALU); #1;
    check_eq("add_issue", 32'(sb_if.issue), 32'd1);
    step();
    go(); set_src(2, 5'd5); #1;
    check_eq("add_use_busy", 32'(sb_if.src_busy), 32'd0);
    check_eq("add_use_issue", 32'(sb_if.issue), 32'd1);
    step();
    go(); set_wr(5'd5, 1'b0, LAT_LOAD); #1;
    check_eq("ld_issue", 32'(sb_if.issue), 32'd1);
    step();
    go(); set_src(2, 5'd5); #1;
    check_eq("ld_use_stall", 32'(sb_if.ds_ready_go), 32'd0);
    step();
    check_eq("ld_use_issue", 32'(sb_if.issue), 32'd1);
    step();
    check_eq("ld_use_cnt", sb_if.stall_cnt, 32'd1);
    exp_stall = 1;
`else
    go(); set_wr(5'd7, 1'b0, 0); #1;
    check_eq("wb_issue", 32'(sb_if.issue), 32'd1);
    step();
    go(); set_src(0, 5'd7); #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("wb_busy%0d", k), 32'(sb_if.src_busy), (k < 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("wb_iss%0d", k), 32'(sb_if.issue), (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    check_eq("wb_stall_cnt", sb_if.stall_cnt, 32'd3);
    exp_stall = 3;
`endif

    // Long op on r9 blocks readers and writers until its completion is seen.
    go(); set_wr(5'd9, 1'b1, 3); #1;
    check_eq("long_issue", 32'(sb_if.issue), 32'd1);
    step();
    go(); set_src(1, 5'd9); #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("long_raw%0d", k), 32'(sb_if.src_busy), 32'b010);
      step();
    end
    exp_stall += 4;
    go(); set_wr(5'd9, 1'b0, 3); #1;
    check_eq("long_waw", 32'(sb_if.ds_ready_go), 32'd0);
    step();
    exp_stall += 1;
    set_src(1, 5'd9);
    sb_if.long_done  = 1'b1;
    sb_if.long_waddr = 5'd9;
    #1;
    check_eq("long_done_cyc", 32'(sb_if.ds_ready_go), 32'd0);
    step();
    exp_stall += 1;
    sb_if.long_done = 1'b0;
    #1;
    check_eq("long_after_busy", 32'(sb_if.src_busy), 32'd0);
    check_eq("long_after_issue", 32'(sb_if.issue), 32'd1);
    step();
    check_eq("long_stall_cnt", sb_if.stall_cnt, 32'(exp_stall));

    // Same-cycle long issue and completion on r10: the set wins.
    go(); set_wr(5'd10, 1'b1, 3);
    sb_if.long_done  = 1'b1;
    sb_if.long_waddr = 5'd10;
    #1;
    check_eq("setwin_issue", 32'(sb_if.issue), 32'd1);
    step();
    go(); set_src(0, 5'd10); #1;
    check_eq("setwin_busy", 32'(sb_if.src_busy), 32'd1);
    step();
    sb_if.long_done  = 1'b1;
    sb_if.long_waddr = 5'd10;
    #1;
    check_eq("setwin_done_busy", 32'(sb_if.src_busy), 32'd1);
    step();
    sb_if.long_done = 1'b0;
    #1;
    check_eq("setwin_clear", 32'(sb_if.src_busy), 32'd0);
    step();
    exp_stall += 2;

    // r0 is never tracked, whether written short or long.
    go(); set_wr(5'd0, 1'b0, 3); step();
    go(); set_wr(5'd0, 1'b1, 3); step();
    go(); set_src(0, 5'd0); set_src(1, 5'd0); set_src(2, 5'd0); set_wr(5'd0, 1'b0, 3); #1;
    check_eq("r0_busy", 32'(sb_if.src_busy), 32'd0);
    check_eq("r0_issue", 32'(sb_if.issue), 32'd1);
    step();

    // Stalled by EX only: no hazard, no issue, no state change.
    idle(); sb_if.ds_valid = 1'b1; set_wr(5'd11, 1'b0, 3); #1;
    check_eq("noallow_ready", 32'(sb_if.ds_ready_go), 32'd1);
    check_eq("noallow_issue", 32'(sb_if.issue), 32'd0);
    step();
    go(); set_src(0, 5'd11); #1;
    check_eq("noallow_nomark", 32'(sb_if.src_busy), 32'd0);
    step();

    // Cancelled instruction leaves no mark and is not counted as a stall.
    go(); sb_if.ds_cancel = 1'b1; set_wr(5'd12, 1'b1, 3); #1;
    check_eq("cancel_issue", 32'(sb_if.issue), 32'd0);
    step();
    go(); set_src(0, 5'd12); #1;
    check_eq("cancel_nomark", 32'(sb_if.src_busy), 32'd0);
    step();
    go(); set_wr(5'd13, 1'b0, 3); step();
    go(); sb_if.ds_cancel = 1'b1; set_src(0, 5'd13); #1;
    check_eq("cancel_haz", 32'(sb_if.ds_ready_go), 32'd0);
    step();
    check_eq("cancel_nocount", sb_if.stall_cnt, 32'(exp_stall));

    // Reset with cnt[5]=2 and lb[9]=1 pending.
    go(); set_wr(5'd9, 1'b1, 3); step();
    go(); set_wr(5'd5, 1'b0, 3); step();
    idle(); step();
    sb_if.ds_valid = 1'b1;
    set_src(0, 5'd5); set_src(1, 5'd9); #1;
    check_eq("pre_rst_busy", 32'(sb_if.src_busy), 32'b011);
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(sb_if.src_busy), 32'd0);
    check_eq("midrst_issue", 32'(sb_if.issue), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_eq("postrst_busy", 32'(sb_if.src_busy), 32'd0);
    check_eq("postrst_stall", sb_if.stall_cnt, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
